// File: rtl/band_mixer.sv
// -----------------------------------------------------------------------------
// band_mixer
//
// Pipelined recombiner for the equalizer output. Sums N_BANDS signed band
// samples into a single output sample:
//
//   stage 0        : input register, per-band enable mask, sign extension
//   stages 1..LVL  : registered balanced binary adder tree at full width
//   stage LVL+1    : arithmetic right shift by SHIFT, saturate to OUT_W
//
// Latency is LVL+2 clocks (in_valid at edge t -> out_valid after edge
// t+LVL+1). One sample per clock, no backpressure, no FSM.
//
// Handshake: in_valid qualifies sig_in/band_en for one cycle only; the block
// always accepts. out_valid qualifies sig_out/sat for one cycle; the
// downstream must always accept. Bubbles in in_valid reach out_valid intact.
//
// Parameters
//   N_BANDS : number of bands, power of two in 2..16
//   IN_W    : signed band sample width
//   OUT_W   : signed output width
//   SHIFT   : arithmetic right shift of the full sum, 0..clog2(N_BANDS)
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   sig_in     : band k at sig_in[k*IN_W +: IN_W], two's complement
//   band_en    : bit k = 0 forces band k to zero for this sample
//   in_valid   : sig_in/band_en valid this cycle
//   sat_clr    : clears sat_sticky (a simultaneous new clip wins)
//   sig_out    : mixed sample, holds its value while out_valid = 0
//   out_valid  : sig_out/sat valid this cycle
//   sat        : this output sample was clipped (0 when out_valid = 0)
//   sat_sticky : a clip has occurred since the last clear or reset
// -----------------------------------------------------------------------------
module band_mixer #(
    parameter int N_BANDS = 8,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BANDS*IN_W-1:0]  sig_in,
    input  logic [N_BANDS-1:0]       band_en,
    input  logic                     in_valid,
    input  logic                     sat_clr,
    output logic [OUT_W-1:0]         sig_out,
    output logic                     out_valid,
    output logic                     sat,
    output logic                     sat_sticky
);

    localparam int LVL     = $clog2(N_BANDS);
    localparam int SUM_W   = IN_W + LVL;
    // Adder tree stored as one flat array: nodes 0..N_BANDS-1 are the stage-0
    // leaves, then each tree level follows the previous one. With this layout
    // the children of node i (i >= N_BANDS) are nodes 2*i-2*N_BANDS and
    // 2*i-2*N_BANDS+1, and the root is the last node.
    localparam int N_NODES = 2 * N_BANDS - 1;
    localparam int ROOT    = N_NODES - 1;
    // Comparison width: wide enough for both the shifted sum and the output
    // limits, plus one bit so the limits never wrap.
    localparam int EXT_W   = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = -(EXT_W'(1) << (OUT_W - 1));

    // -------------------------------------------------------------------------
    // Stage 0 .. LVL : leaves and adder tree
    // -------------------------------------------------------------------------
    logic signed [SUM_W-1:0] node_q [N_NODES];
    logic signed [SUM_W-1:0] node_d [N_NODES];
    // vld_q[l] is the valid bit of tree level l (level 0 = input register).
    logic [LVL:0]            vld_q;
    logic [LVL:0]            vld_d;

    always_comb begin
        node_d = node_q;
        vld_d  = {vld_q[LVL-1:0], in_valid};

        // Leaves only load on a valid sample, so band_en is sampled with
        // in_valid alone; idle cycles leave the leaves untouched.
        if (in_valid) begin
            for (int k = 0; k < N_BANDS; k++) begin
                if (band_en[k]) begin
                    node_d[k] = {{LVL{sig_in[k*IN_W+IN_W-1]}}, sig_in[k*IN_W +: IN_W]};
                end else begin
                    node_d[k] = '0;
                end
            end
        end

        // Every tree level registers the pairwise sum of the level below.
        // SUM_W bits hold N_BANDS * 2^(IN_W-1) in magnitude, so no wrap.
        for (int i = N_BANDS; i < N_NODES; i++) begin
            node_d[i] = node_q[2*i-2*N_BANDS] + node_q[2*i-2*N_BANDS+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                node_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            node_q <= node_d;
            vld_q  <= vld_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage LVL+1 : scale and saturate
    // -------------------------------------------------------------------------
    logic signed [SUM_W-1:0] shifted;
    logic signed [EXT_W-1:0] s_ext;
    logic [OUT_W-1:0]        clip_val;
    logic                    clip_hit;

    // >>> on a signed operand floors toward minus infinity.
    assign shifted = node_q[ROOT] >>> SHIFT;
    assign s_ext   = {{(EXT_W-SUM_W){shifted[SUM_W-1]}}, shifted};

    // When OUT_W >= SUM_W-SHIFT the shifted sum always fits, both compares
    // are constant false and clip_hit reduces to 0.
    always_comb begin
        clip_val = s_ext[OUT_W-1:0];
        clip_hit = 1'b0;
        if (s_ext > SAT_MAX) begin
            clip_val = SAT_MAX[OUT_W-1:0];
            clip_hit = 1'b1;
        end else if (s_ext < SAT_MIN) begin
            clip_val = SAT_MIN[OUT_W-1:0];
            clip_hit = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output registers and sticky flag
    // -------------------------------------------------------------------------
    logic [OUT_W-1:0] sig_out_q, sig_out_d;
    logic             out_valid_q, out_valid_d;
    logic             sat_q, sat_d;
    logic             sticky_q, sticky_d;

    always_comb begin
        out_valid_d = vld_q[LVL];
        sat_d       = vld_q[LVL] & clip_hit;
        sig_out_d   = sig_out_q;
        if (vld_q[LVL]) begin
            sig_out_d = clip_val;
        end
        // A clip wins over sat_clr whether the clear lines up with the edge
        // that produces the clipped sample or with the cycle it is shown in.
        sticky_d = (out_valid_d & sat_d)
                 | (out_valid_q & sat_q)
                 | (sticky_q & ~sat_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_out_q   <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            sig_out_q   <= sig_out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            sticky_q    <= sticky_d;
        end
    end

    assign sig_out    = sig_out_q;
    assign out_valid  = out_valid_q;
    assign sat        = sat_q;
    assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_band_mixer.sv
// -----------------------------------------------------------------------------
// tb_band_mixer
//
// Three band_mixer instances share one 16-band stimulus bus:
//   dut 0 : N_BANDS=8,  IN_W=16, OUT_W=16, SHIFT=0 (default, latency 5)
//   dut 1 : N_BANDS=4,  IN_W=16, OUT_W=16, SHIFT=2 (latency 4)
//   dut 2 : N_BANDS=16, IN_W=16, OUT_W=20, SHIFT=0 (latency 6, never clips)
// Each instance has a reference model: the sample value is computed with
// plain integer arithmetic (sum, floor division, clip) and delayed through a
// queue of the instance's latency.
// -----------------------------------------------------------------------------
module tb_band_mixer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic         sat_clr  = 1'b0;
    logic [255:0] sig_bus  = '0;
    logic [15:0]  en_bus   = '0;

    logic [15:0] a_out;  logic a_ov, a_sat, a_st;
    logic [15:0] b_out;  logic b_ov, b_sat, b_st;
    logic [19:0] c_out;  logic c_ov, c_sat, c_st;

    band_mixer #(.N_BANDS(8), .IN_W(16), .OUT_W(16), .SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_bus[127:0]), .band_en(en_bus[7:0]),
        .in_valid(in_valid), .sat_clr(sat_clr), .sig_out(a_out),
        .out_valid(a_ov), .sat(a_sat), .sat_sticky(a_st));

    band_mixer #(.N_BANDS(4), .IN_W(16), .OUT_W(16), .SHIFT(2)) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_bus[63:0]), .band_en(en_bus[3:0]),
        .in_valid(in_valid), .sat_clr(sat_clr), .sig_out(b_out),
        .out_valid(b_ov), .sat(b_sat), .sat_sticky(b_st));

    band_mixer #(.N_BANDS(16), .IN_W(16), .OUT_W(20), .SHIFT(0)) dut_c (
        .clk(clk), .rst(rst), .sig_in(sig_bus), .band_en(en_bus),
        .in_valid(in_valid), .sat_clr(sat_clr), .sig_out(c_out),
        .out_valid(c_ov), .sat(c_sat), .sat_sticky(c_st));

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          v;
        logic [63:0] d;
        bit          s;
    } exp_t;

    exp_t        pipe [3][$];
    int          nb_cfg  [3] = '{8, 4, 16};
    int          sh_cfg  [3] = '{0, 2, 0};
    int          ow_cfg  [3] = '{16, 16, 20};
    int          lat_cfg [3] = '{5, 4, 6};
    logic [63:0] hold_m  [3];
    bit          last_v  [3];
    bit          last_s  [3];
    bit          sticky_m[3];

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference value of one sample: sum enabled bands, divide by 2^shift
    // rounding toward minus infinity, clip to the signed output range.
    // Returned value is masked to the output width.
    task automatic model(input int nb, input int sh, input int ow,
                         input logic [255:0] sig, input logic [15:0] en,
                         output logic [63:0] val, output bit clipped);
        longint  sum = 0;
        longint  div, q, mx, mn;
        shortint band;
        for (int k = 0; k < nb; k++) begin
            band = sig[k*16 +: 16];
            if (en[k]) sum += band;
        end
        div = longint'(1) << sh;
        q   = sum / div;
        if ((sum % div) != 0 && sum < 0) q = q - 1;
        mx = (longint'(1) << (ow - 1)) - 1;
        mn = -(longint'(1) << (ow - 1));
        clipped = 1'b0;
        if (q > mx) begin
            q = mx; clipped = 1'b1;
        end else if (q < mn) begin
            q = mn; clipped = 1'b1;
        end
        val = 64'(q) & ((64'd1 << ow) - 64'd1);
    endtask

    task automatic observe(input int d, output logic [63:0] o, output logic v,
                           output logic s, output logic st);
        case (d)
            0:       begin o = {48'b0, a_out}; v = a_ov; s = a_sat; st = a_st; end
            1:       begin o = {48'b0, b_out}; v = b_ov; s = b_sat; st = b_st; end
            default: begin o = {44'b0, c_out}; v = c_ov; s = c_sat; st = c_st; end
        endcase
    endtask

    // ---------------- driver: one clock cycle + scoreboard ----------------
    task automatic cycle(input bit r, input bit v, input logic [255:0] sig,
                         input logic [15:0] en, input bit clr);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        sig_bus  = sig;
        en_bus   = en;
        sat_clr  = clr;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_t        e, nxt;
            logic [63:0] eo, oo;
            bit          ev, es, est;
            logic        ov, os, ost;
            if (r) begin
                pipe[d].delete();
                for (int i = 0; i < lat_cfg[d] - 1; i++) begin
                    e.v = 1'b0; e.d = '0; e.s = 1'b0;
                    pipe[d].push_back(e);
                end
                hold_m[d] = '0; last_v[d] = 0; last_s[d] = 0; sticky_m[d] = 0;
                ev = 0; es = 0; eo = '0; est = 0;
            end else begin
                model(nb_cfg[d], sh_cfg[d], ow_cfg[d], sig, en, e.d, e.s);
                e.v = v;
                pipe[d].push_back(e);
                nxt = pipe[d].pop_front();
                ev  = nxt.v;
                es  = nxt.v & nxt.s;
                if (nxt.v) hold_m[d] = nxt.d;
                eo  = hold_m[d];
                est = (ev & es) | (last_v[d] & last_s[d]) | (sticky_m[d] & !clr);
                sticky_m[d] = est;
                last_v[d]   = ev;
                last_s[d]   = es;
            end
            observe(d, oo, ov, os, ost);
            chk($sformatf("dut%0d out_valid", d), {63'b0, ov}, {63'b0, ev});
            chk($sformatf("dut%0d sig_out", d), oo, eo);
            chk($sformatf("dut%0d sat", d), {63'b0, os}, {63'b0, es});
            chk($sformatf("dut%0d sat_sticky", d), {63'b0, ost}, {63'b0, est});
        end
    endtask

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, clr);
    endtask

    function automatic logic [255:0] all_same(input logic [15:0] x);
        return {16{x}};
    endfunction

    function automatic logic [255:0] ramp();
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(k + 1);
        return r;
    endfunction

    function automatic logic [255:0] rand_sig();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [255:0] mask_sig;

        // Reset state
        cycle(1, 0, '0, '0, 0);
        cycle(1, 1, rand_sig(), 16'hFFFF, 0);
        chk("reset a out_valid", {63'b0, a_ov}, 64'd0);
        chk("reset a sig_out", {48'b0, a_out}, 64'd0);
        chk("reset a sat_sticky", {63'b0, a_st}, 64'd0);

        // Sum and latency: bands k+1, all enabled
        cycle(0, 1, ramp(), 16'hFFFF, 0);
        idle(3, 0);
        chk("sum a early out_valid", {63'b0, a_ov}, 64'd0);
        idle(1, 0);
        chk("sum a out_valid", {63'b0, a_ov}, 64'd1);
        chk("sum a sig_out", {48'b0, a_out}, 64'd36);
        chk("sum a sat", {63'b0, a_sat}, 64'd0);
        chk("sum c early out_valid", {63'b0, c_ov}, 64'd0);
        idle(1, 0);
        chk("sum a single pulse", {63'b0, a_ov}, 64'd0);
        chk("sum c out_valid", {63'b0, c_ov}, 64'd1);
        chk("sum c sig_out", {44'b0, c_out}, 64'd136);
        idle(2, 0);

        // Saturation both directions, then sticky clear
        cycle(0, 1, all_same(16'h7FFF), 16'hFFFF, 0);
        cycle(0, 1, all_same(16'h8000), 16'hFFFF, 0);
        idle(3, 0);
        chk("satpos a sig_out", {48'b0, a_out}, 64'h7FFF);
        chk("satpos a sat", {63'b0, a_sat}, 64'd1);
        chk("satpos a sticky", {63'b0, a_st}, 64'd1);
        chk("satpos b no clip", {63'b0, b_sat}, 64'd0);
        idle(1, 0);
        chk("satneg a sig_out", {48'b0, a_out}, 64'h8000);
        chk("satneg a sat", {63'b0, a_sat}, 64'd1);
        idle(1, 0);
        idle(1, 1);
        chk("clr a sticky", {63'b0, a_st}, 64'd0);
        // Clear coinciding with a new clipped output: set wins
        cycle(0, 1, all_same(16'h7FFF), 16'hFFFF, 0);
        idle(3, 0);
        idle(1, 1);
        chk("set-wins a sat", {63'b0, a_sat}, 64'd1);
        chk("set-wins a sticky", {63'b0, a_st}, 64'd1);
        idle(1, 1);
        idle(1, 1);
        chk("clr2 a sticky", {63'b0, a_st}, 64'd0);

        // Masking and signs
        mask_sig = '0;
        mask_sig[15:0]  = 16'hFF9C;  // -100
        mask_sig[31:16] = 16'd50;
        mask_sig[47:32] = 16'd50;
        mask_sig[63:48] = 16'd7;
        cycle(0, 1, mask_sig, 16'h0007, 0);
        cycle(0, 1, mask_sig, 16'h0008, 0);
        idle(3, 0);
        chk("mask07 a sig_out", {48'b0, a_out}, 64'd0);
        idle(1, 0);
        chk("mask08 a sig_out", {48'b0, a_out}, 64'd7);

        // Shift floors toward minus infinity (dut1): all -1 -> -4 >>> 2 = -1
        cycle(0, 1, all_same(16'hFFFF), 16'hFFFF, 0);
        idle(3, 0);
        chk("floor b sig_out", {48'b0, b_out}, 64'hFFFF);
        chk("floor b sat", {63'b0, b_sat}, 64'd0);
        idle(3, 0);

        // Throughput: 64 back-to-back random vectors with random masks
        for (int i = 0; i < 64; i++) begin
            cycle(0, 1, rand_sig(), 16'($urandom), 0);
        end
        // Gaps and random clears
        for (int i = 0; i < 120; i++) begin
            cycle(0, $urandom_range(0, 2) != 0, rand_sig(), 16'($urandom),
                  $urandom_range(0, 5) == 0);
        end
        idle(6, 0);

        // Reset mid-stream: first sample clips so sat_sticky is set
        cycle(0, 1, all_same(16'h7FFF), 16'hFFFF, 0);
        for (int i = 1; i < 10; i++) begin
            cycle(0, 1, rand_sig(), 16'($urandom), 0);
            if (i == 6) begin
                chk("midrst a third out", {63'b0, a_ov}, 64'd1);
                cycle(1, 1, rand_sig(), 16'hFFFF, 0);
                chk("midrst a out_valid", {63'b0, a_ov}, 64'd0);
                chk("midrst a sticky", {63'b0, a_st}, 64'd0);
                break;
            end
        end
        cycle(0, 1, ramp(), 16'hFFFF, 0);
        idle(3, 0);
        chk("postrst a early", {63'b0, a_ov}, 64'd0);
        idle(1, 0);
        chk("postrst a out_valid", {63'b0, a_ov}, 64'd1);
        chk("postrst a sig_out", {48'b0, a_out}, 64'd36);
        idle(6, 0);

        // Final random burst with resets sprinkled in
        for (int i = 0; i < 80; i++) begin
            cycle($urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0, rand_sig(),
                  16'($urandom), $urandom_range(0, 7) == 0);
        end
        idle(8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
